// File: rtl/ps2_key_fifo_if.sv
// rtl/ps2_key_fifo_if.sv - PS/2 scancode strobe input and processor read-side signals of the key FIFO.
interface ps2_key_fifo_if #(
  parameter int DEPTH = 8
);
  logic                     ps2_key_pressed;
  logic [7:0]               ps2_out;
  logic                     rd_en;
  logic                     clear_ovf;
  logic [31:0]              rd_data;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output ps2_key_pressed, ps2_out, rd_en, clear_ovf,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  ps2_key_pressed, ps2_out, rd_en, clear_ovf,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - Show-ahead scancode FIFO with E0/F0 prefix decoding and sticky overflow.
module ps2_key_fifo #(
  parameter int DEPTH        = 8,
  parameter int FILTER_BREAK = 1
) (
  input  logic          clock,
  input  logic          reset,
  ps2_key_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BREAK} state_t;

  state_t         state, state_nxt;
  logic [8:0]     mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count_q;
  logic           ovf_q;
  logic           store, store_ext;
  logic           is_empty, is_full, pop, do_push, ovf_evt;

  // Prefix bytes are swallowed here, so they never reach the push/overflow path.
  always_comb begin
    store     = 1'b0;
    store_ext = 1'b0;
    state_nxt = state;
    if (bus.ps2_key_pressed) begin
      if (FILTER_BREAK == 0) begin
        store = 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.ps2_out == 8'hF0)      state_nxt = S_BREAK;
            else if (bus.ps2_out == 8'hE0) state_nxt = S_EXT;
            else                           store = 1'b1;
          end
          S_EXT: begin
            if (bus.ps2_out == 8'hF0) begin
              state_nxt = S_BREAK;
            end else if (bus.ps2_out != 8'hE0) begin
              store     = 1'b1;
              store_ext = 1'b1;
              state_nxt = S_IDLE;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign pop      = bus.rd_en && !is_empty;
  assign do_push  = store && (!is_full || pop);
  assign ovf_evt  = store && is_full && !pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_push) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A fresh overflow outranks a same-cycle clear.
      if (ovf_evt)            ovf_q <= 1'b1;
      else if (bus.clear_ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= {store_ext, bus.ps2_out};
  end

  assign bus.rd_data  = is_empty ? 32'd0 : {23'd0, mem[rptr]};
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/ps2_key_fifo.md
PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 8; FIFO entry count; power of two, 2..64.
REQ-002 SHALL provide parameter FILTER_BREAK, default 1; 1 = decode scancode prefixes, 0 = store every byte raw.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_key_pressed  input  1  one-cycle strobe marking a valid ps2_out byte.
REQ-006 ps2_out  input  8  scancode byte from the PS/2 receiver.
REQ-007 rd_en  input  1  processor pop request; one entry per asserted cycle.
REQ-008 clear_ovf  input  1  clears the overflow flag.
REQ-009 rd_data  output  32  head entry, zero-extended as {23'b0, ext, code[7:0]}; 0 when empty.
REQ-010 empty  output  1  high when count = 0.
REQ-011 full  output  1  high when count = DEPTH.
REQ-012 count  output  clog2(DEPTH)+1  number of stored entries.
REQ-013 overflow  output  1  sticky flag; an entry was lost to a full FIFO.

Function
REQ-014 Storage SHALL be a circular buffer of 9-bit entries {ext, code} with read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 Reads SHALL be show-ahead: rd_data presents the head entry whenever empty = 0, with no request needed.
REQ-016 A byte strobed in cycle N SHALL be visible on rd_data, with empty low, from cycle N+1.
REQ-017 The prefix decoder (FILTER_BREAK=1) SHALL have states IDLE, EXT and BREAK; reset state IDLE.
REQ-018 In IDLE, each strobed byte SHALL be handled as follows:
- 0xF0: go to BREAK, store nothing.
- 0xE0: go to EXT, store nothing.
- Any other byte: store {0, byte}, stay in IDLE.
REQ-019 In EXT, each strobed byte SHALL be handled as follows:
- 0xF0: go to BREAK, store nothing.
- 0xE0: stay in EXT, store nothing.
- Any other byte: store {1, byte}, return to IDLE.
REQ-020 In BREAK, the next strobed byte SHALL be discarded and the state SHALL return to IDLE.
REQ-021 State SHALL change only on cycles where ps2_key_pressed = 1.
REQ-022 With FILTER_BREAK=0, every strobed byte SHALL be stored as {0, byte} and the decoder SHALL stay in IDLE.
REQ-023 A pop SHALL occur when rd_en = 1 and empty = 0: the read pointer advances and count decrements.
REQ-024 rd_en while empty SHALL be ignored; pointers, count and flags are unchanged.
REQ-025 Push and pop in the same cycle SHALL both take effect with count unchanged, including when full.
REQ-026 A push while full without a simultaneous pop SHALL discard the entry, keep pointers and count unchanged, and set overflow.
REQ-027 overflow SHALL stay set until clear_ovf = 1.
REQ-028 When clear_ovf coincides with a new overflow event, set SHALL win.
REQ-029 A prefix byte that is consumed by the decoder and not stored SHALL never set overflow.
REQ-030 count SHALL never exceed DEPTH or go below 0.
REQ-031 full and empty SHALL be decoded from count, so full and empty are never high together.

Reset
REQ-032 While reset = 1, asynchronously:
- Pointers, count and overflow SHALL be 0.
- Decoder state SHALL be IDLE.
- Outputs SHALL be empty = 1, full = 0, rd_data = 0, count = 0, overflow = 0.
REQ-033 Reset mid-operation SHALL discard all stored entries and any pending prefix.
REQ-034 Entry storage contents need not be cleared, but SHALL never be visible while empty = 1.
REQ-035 The first strobe after reset is released SHALL be accepted normally.

Verification
REQ-036 Strobe 0x1C -> next cycle: rd_data = 0x0000001C, empty = 0, count = 1. Pulse rd_en -> empty = 1, rd_data = 0.
REQ-037 Strobe 0xE0, 0x75 -> one entry 0x00000175. Strobe 0xF0, 0x1C -> no entry; count stays 1, state IDLE.
REQ-038 Strobe 0xE0, 0xF0, 0x75 -> no entry stored. A following 0x1C -> entry 0x0000001C.
REQ-039 DEPTH=8: push 8 bytes 0x01..0x08.
- full = 1 after the 8th push.
- 9th push 0x09 -> dropped, overflow = 1, count = 8.
- Pops then return 0x01..0x08 in order.
- clear_ovf -> overflow = 0.
REQ-040 Full FIFO, simultaneous strobe 0x2A and rd_en -> head advances, count stays 8, overflow stays 0, and 0x2A is read last. Run 20 push/pop cycles across pointer wrap with order preserved.
REQ-041 Assert reset after 3 pushes and a pending 0xF0 -> empty = 1, count = 0. After release, strobe 0x1C -> stored (not swallowed as a break byte).
